// File: rtl/cache_pkg.sv
// cache_pkg: shared constants and types for the cache-line / burst-memory adaptor.
//   LINE_WIDTH  - cache line width in bits
//   BURST_WIDTH - memory beat width in bits
//   ADDR_WIDTH  - byte address width
//   BEATS       - beats per line (derived)
package cache_pkg;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W       = $clog2(BEATS);
  // byte-offset bits inside one line; cleared on the outgoing burst address
  localparam int OFFS_W      = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_e;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a 256-bit cache line port to a 64-bit burst memory port.
//   A line read becomes a BEATS-beat burst read assembled into line_o; a line
//   write-back becomes a BEATS-beat burst write sliced out of the latched line.
//   Completion is a single-cycle resp_o pulse to the cache.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   line_i / line_o     - write-back line in / assembled read line out
//   address_i           - line address from cache
//   read_i / write_i    - cache requests, held until resp_o
//   resp_o              - transfer complete pulse
//   burst_i / burst_o   - memory read beat in / write beat out
//   address_o           - line-aligned burst address to memory
//   read_o / write_o    - burst requests to memory
//   resp_i              - memory beat accepted / valid
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  adaptor_state_e          state_q;
  logic [CNT_W-1:0]        cnt_q;
  line_t                   rbuf_q;   // read line being assembled / last read line
  line_t                   wbuf_q;   // latched write-back line
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    read_q, write_q, resp_q;

  logic                    last_beat;
  assign last_beat = resp_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          cnt_q  <= '0;
          // write-back has priority: a dirty victim must leave before the fill
          if (write_i) begin
            wbuf_q  <= line_i;
            addr_q  <= {address_i[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
            write_q <= 1'b1;
            state_q <= WRITE;
          end else if (read_i) begin
            rbuf_q  <= '0;
            addr_q  <= {address_i[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
            read_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            rbuf_q[cnt_q*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            cnt_q <= cnt_q + 1'b1;   // wraps to 0 after the last beat
          end
          if (last_beat) begin
            read_q  <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) cnt_q <= cnt_q + 1'b1;
          if (last_beat) begin
            write_q <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign burst_o   = wbuf_q[cnt_q*BURST_WIDTH +: BURST_WIDTH];
  assign line_o    = rbuf_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rd, wr, rsp;
    logic [31:0]  ai;
    logic [63:0]  bi;
    logic [255:0] li;
    logic e_rd, e_wr, e_resp;
    logic chk_b; logic [63:0]  e_b;
    logic chk_a; logic [31:0]  e_a;
    logic chk_l; logic [255:0] e_l;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  logic [31:0]  cur_ai;
  logic [255:0] cur_li;

  localparam logic [63:0] R1 = 64'h1111_1111_1111_1111, R2 = 64'h2222_2222_2222_2222,
                          R3 = 64'h3333_3333_3333_3333, R4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA, WB = 64'hBBBB_BBBB_BBBB_BBBB,
                          WC = 64'hCCCC_CCCC_CCCC_CCCC, WD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] G0 = 64'h0123_4567_89AB_CDEF, G1 = 64'hFEDC_BA98_7654_3210,
                          G2 = 64'h0F0F_0F0F_F0F0_F0F0, G3 = 64'h5A5A_A5A5_5A5A_A5A5;
  localparam logic [63:0] JK = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] V5 = 64'h5555_5555_5555_5555, V6 = 64'h6666_6666_6666_6666,
                          V7 = 64'h7777_7777_7777_7777, V8 = 64'h8888_8888_8888_8888;
  localparam logic [63:0] F1 = 64'h1000_0000_0000_0001, F2 = 64'h2000_0000_0000_0002,
                          F3 = 64'h3000_0000_0000_0003, F4 = 64'h4000_0000_0000_0004;
  localparam logic [63:0] Q0 = 64'h9999_0000_0000_0000, Q1 = 64'h9999_1111_0000_0000,
                          Q2 = 64'h9999_2222_0000_0000;
  localparam logic [63:0] P0 = 64'hC0C0_0000_0000_0000, P1 = 64'hC1C1_0000_0000_0000,
                          P2 = 64'hC2C2_0000_0000_0000, P3 = 64'hC3C3_0000_0000_0000;

  // one cycle of stimulus plus the control outputs expected during that cycle
  function automatic vec_t cy(input logic r, rd, wr, rsp, input logic [63:0] bi,
                              input logic erd, ewr, eresp);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.rsp = rsp; v.ai = cur_ai; v.bi = bi; v.li = cur_li;
    v.e_rd = erd; v.e_wr = ewr; v.e_resp = eresp;
    v.chk_b = 1'b0; v.e_b = '0;
    v.chk_a = 1'b0; v.e_a = '0;
    v.chk_l = 1'b0; v.e_l = '0;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask
  task automatic exp_b(input logic [63:0] b);
    tbl[tbl.size()-1].chk_b = 1'b1; tbl[tbl.size()-1].e_b = b;
  endtask
  task automatic exp_a(input logic [31:0] a);
    tbl[tbl.size()-1].chk_a = 1'b1; tbl[tbl.size()-1].e_a = a;
  endtask
  task automatic exp_l(input logic [255:0] l);
    tbl[tbl.size()-1].chk_l = 1'b1; tbl[tbl.size()-1].e_l = l;
  endtask

  task automatic chk1(input string nm, input int idx, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0b want=%0b", nm, idx, act, req);
    end
  endtask

  task automatic chkw(input string nm, input int idx, input logic [255:0] act,
                      input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, req);
    end
  endtask

  initial begin
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    burst_i = '0; line_i = '0; address_i = '0;

    // ---- test 1: read, resp_i every cycle
    cur_ai = 32'h0000_1234; cur_li = '0;
    add(cy(0,1,0,0,'0, 0,0,0)); exp_l('0);
    add(cy(0,1,0,1,R1, 1,0,0)); exp_a(32'h0000_1220);
    add(cy(0,1,0,1,R2, 1,0,0));
    add(cy(0,1,0,1,R3, 1,0,0));
    add(cy(0,1,0,1,R4, 1,0,0)); exp_a(32'h0000_1220);
    add(cy(0,1,0,0,'0, 0,0,1)); exp_l({R4,R3,R2,R1}); exp_a(32'h0000_1220);
    add(cy(0,0,0,0,'0, 0,0,0)); exp_l({R4,R3,R2,R1});

    // ---- test 2: read with resp_i gaps 1,0,0,1,1,0,1; address_i changes mid-burst
    cur_ai = 32'h0000_ABCD;
    add(cy(0,1,0,0,'0, 0,0,0));
    add(cy(0,1,0,1,G0, 1,0,0)); exp_l('0);
    cur_ai = 32'hFFFF_FFFF;
    add(cy(0,1,0,0,JK, 1,0,0)); exp_a(32'h0000_ABC0);
    add(cy(0,1,0,0,JK, 1,0,0));
    add(cy(0,1,0,1,G1, 1,0,0));
    add(cy(0,1,0,1,G2, 1,0,0));
    add(cy(0,1,0,0,JK, 1,0,0));
    add(cy(0,1,0,1,G3, 1,0,0));
    add(cy(0,1,0,0,'0, 0,0,1)); exp_l({G3,G2,G1,G0}); exp_a(32'h0000_ABC0);
    add(cy(0,0,0,0,'0, 0,0,0));

    // ---- test 3: write with one stall; line_i changes mid-burst; resp_i in IDLE ignored
    cur_ai = 32'h0000_5678; cur_li = {WD,WC,WB,WA};
    add(cy(0,0,1,1,'0, 0,0,0));
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(WA); exp_a(32'h0000_5660);
    cur_li = '1;
    add(cy(0,0,1,0,'0, 0,1,0)); exp_b(WB);
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(WB);
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(WC);
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(WD);
    add(cy(0,0,1,1,'0, 0,0,1)); exp_l({G3,G2,G1,G0});
    add(cy(0,0,0,0,'0, 0,0,0));

    // ---- test 4: dirty eviction, write-back then fill
    cur_ai = 32'h0000_2040; cur_li = {V8,V7,V6,V5};
    add(cy(0,0,1,0,'0, 0,0,0));
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(V5); exp_a(32'h0000_2040);
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(V6);
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(V7);
    add(cy(0,0,1,1,'0, 0,1,0)); exp_b(V8);
    add(cy(0,0,1,0,'0, 0,0,1));
    add(cy(0,1,0,0,'0, 0,0,0));
    add(cy(0,1,0,1,F1, 1,0,0)); exp_l('0);
    add(cy(0,1,0,1,F2, 1,0,0));
    add(cy(0,1,0,1,F3, 1,0,0));
    add(cy(0,1,0,1,F4, 1,0,0));
    add(cy(0,1,0,0,'0, 0,0,1)); exp_l({F4,F3,F2,F1});
    add(cy(0,0,0,0,'0, 0,0,0));

    // ---- test 5: read and write together -> write only
    cur_ai = 32'h0000_3001; cur_li = {WA,WB,WC,WD};
    add(cy(0,1,1,0,'0, 0,0,0));
    add(cy(0,1,1,1,'0, 0,1,0)); exp_b(WD); exp_a(32'h0000_3000);
    add(cy(0,1,1,1,'0, 0,1,0)); exp_b(WC);
    add(cy(0,1,1,1,'0, 0,1,0)); exp_b(WB);
    add(cy(0,1,1,1,'0, 0,1,0)); exp_b(WA);
    add(cy(0,1,1,0,'0, 0,0,1)); exp_l({F4,F3,F2,F1});
    add(cy(0,0,0,0,'0, 0,0,0));

    // ---- test 6: reset after two read beats, then a clean read
    cur_ai = 32'h0000_4444;
    add(cy(0,1,0,0,'0, 0,0,0));
    add(cy(0,1,0,1,Q0, 1,0,0));
    add(cy(0,1,0,1,Q1, 1,0,0));
    add(cy(1,1,0,1,Q2, 1,0,0)); exp_a(32'h0000_4440);
    add(cy(0,0,0,1,'0, 0,0,0)); exp_l('0); exp_a('0); exp_b('0);
    add(cy(0,0,0,0,'0, 0,0,0));
    cur_ai = 32'h0000_0020;
    add(cy(0,1,0,0,'0, 0,0,0));
    add(cy(0,1,0,1,P0, 1,0,0)); exp_a(32'h0000_0020);
    add(cy(0,1,0,1,P1, 1,0,0));
    add(cy(0,1,0,1,P2, 1,0,0));
    add(cy(0,1,0,1,P3, 1,0,0));
    add(cy(0,1,0,0,'0, 0,0,1)); exp_l({P3,P2,P1,P0});
    add(cy(0,0,0,0,'0, 0,0,0));

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_read_o", -1, read_o, 1'b0);
    chk1("rst_write_o", -1, write_o, 1'b0);
    chk1("rst_resp_o", -1, resp_o, 1'b0);
    chkw("rst_line_o", -1, line_o, '0);
    chkw("rst_burst_o", -1, {192'b0, burst_o}, '0);
    chkw("rst_address_o", -1, {224'b0, address_o}, '0);

    // ---- apply table: drive a cycle's inputs, check that cycle's outputs, clock
    foreach (tbl[i]) begin
      rst = tbl[i].rst; read_i = tbl[i].rd; write_i = tbl[i].wr; resp_i = tbl[i].rsp;
      address_i = tbl[i].ai; burst_i = tbl[i].bi; line_i = tbl[i].li;
      chk1("read_o", i, read_o, tbl[i].e_rd);
      chk1("write_o", i, write_o, tbl[i].e_wr);
      chk1("resp_o", i, resp_o, tbl[i].e_resp);
      if (tbl[i].chk_b) chkw("burst_o", i, {192'b0, burst_o}, {192'b0, tbl[i].e_b});
      if (tbl[i].chk_a) chkw("address_o", i, {224'b0, address_o}, {224'b0, tbl[i].e_a});
      if (tbl[i].chk_l) chkw("line_o", i, line_o, tbl[i].e_l);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
